// File: rtl/apb_poll_timer_pkg.sv
// -----------------------------------------------------------------------------
// apb_poll_timer_pkg
// Shared constants for the APB poll timer:
//   - register byte offsets
//   - CTRL abort-field bit base
//   - LOAD reset value
//   - legal channel-count range
//   - register-select enum used by the address decoder
// -----------------------------------------------------------------------------
package apb_poll_timer_pkg;

    localparam int C_OFF_CTRL        = 'h00;
    localparam int C_OFF_STATUS      = 'h04;
    localparam int C_OFF_DONE        = 'h08;
    localparam int C_OFF_IRQ_EN      = 'h0C;
    localparam int C_OFF_LOAD_BASE   = 'h10;

    // CTRL: bit[ch] starts a channel, bit[C_CTRL_ABORT_BASE+ch] aborts it.
    localparam int C_CTRL_ABORT_BASE = 16;

    localparam int C_LOAD_RST_VAL    = 15;

    localparam int C_NUM_CH_MIN      = 1;
    localparam int C_NUM_CH_MAX      = 16;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_STATUS,
        REG_DONE,
        REG_IRQ_EN,
        REG_LOAD
    } reg_sel_e;

endpackage

// File: rtl/apb_poll_timer_ch.sv
// -----------------------------------------------------------------------------
// apb_poll_timer_ch
// One countdown channel. A start loads the counter and raises busy. Busy then
// stays high for LOAD+1 cycles. The terminal cycle (cnt==0) emits a
// combinational done pulse, so the owner can set DONE on the same edge that
// busy clears.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_start       - (re)load counter from i_load and go busy (wins over abort)
//   i_abort       - drop busy and clear counter, no done
//   i_load        - reload value
//   o_busy        - channel busy flag
//   o_done_pulse  - high on the natural terminal cycle only
// -----------------------------------------------------------------------------
module apb_poll_timer_ch #(
    parameter int G_CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [G_CNT_WIDTH-1:0] i_load,
    output logic                   o_busy,
    output logic                   o_done_pulse
);

    logic                   r_busy;
    logic [G_CNT_WIDTH-1:0] r_cnt;
    logic                   w_terminal;

    assign w_terminal = r_busy && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            // Covers restart, including restart on the terminal cycle.
            r_busy <= 1'b1;
            r_cnt  <= i_load;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (w_terminal) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_cnt  <= r_cnt - G_CNT_WIDTH'(1);
        end
    end

    // A start or abort landing on the terminal cycle suppresses completion.
    assign o_done_pulse = w_terminal && !i_start && !i_abort;
    assign o_busy       = r_busy;

endmodule

// File: rtl/apb_poll_timer.sv
// -----------------------------------------------------------------------------
// apb_poll_timer
// APB slave with G_NUM_CH independent countdown channels.
// Zero-wait-state APB interface; prdata is combinational in the read access
// phase. A level irq is raised when any channel's DONE and IRQ_EN bits are
// both set.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   s_apb_*                      - APB slave (pprot/pstrb accepted, ignored)
//   busy[G_NUM_CH-1:0]           - per-channel busy flags
//   irq                          - OR of (DONE & IRQ_EN)
// Register map (byte offsets):
//   0x00 CTRL   (WO)
//   0x04 STATUS (RO)
//   0x08 DONE   (W1C)
//   0x0C IRQ_EN (RW)
//   0x10+4*ch LOAD[ch] (RW)
// -----------------------------------------------------------------------------
module apb_poll_timer
    import apb_poll_timer_pkg::*;
#(
    parameter int G_REGWIDTH   = 32,
    parameter int G_ADDR_WIDTH = 7,
    parameter int G_NUM_CH     = 4,
    parameter int G_CNT_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_apb_psel,
    input  logic                      s_apb_penable,
    input  logic                      s_apb_pwrite,
    input  logic [2:0]                s_apb_pprot,
    input  logic [G_ADDR_WIDTH-1:0]   s_apb_paddr,
    input  logic [G_REGWIDTH-1:0]     s_apb_pwdata,
    input  logic [G_REGWIDTH/8-1:0]   s_apb_pstrb,
    output logic                      s_apb_pready,
    output logic [G_REGWIDTH-1:0]     s_apb_prdata,
    output logic                      s_apb_pslverr,
    output logic [G_NUM_CH-1:0]       busy,
    output logic                      irq
);

    if (G_NUM_CH < C_NUM_CH_MIN || G_NUM_CH > C_NUM_CH_MAX) begin : g_bad_num_ch
        $error("apb_poll_timer: G_NUM_CH out of range");
    end

    logic                   w_access;
    logic                   w_wr;
    logic                   w_rd;
    reg_sel_e               w_sel;
    int                     w_addr;
    int                     w_load_idx;
    logic [G_NUM_CH-1:0]    w_start;
    logic [G_NUM_CH-1:0]    w_abort;
    logic [G_NUM_CH-1:0]    w_load_we;
    logic [G_NUM_CH-1:0]    w_done_pulse;
    logic [G_NUM_CH-1:0]    w_done_w1c;
    logic [G_REGWIDTH-1:0]  w_rdata;
    logic                   w_unused_apb;

    logic [G_NUM_CH-1:0]    r_done;
    logic [G_NUM_CH-1:0]    r_irq_en;
    logic [G_CNT_WIDTH-1:0] r_load [G_NUM_CH];

    assign w_access = s_apb_psel && s_apb_penable;
    assign w_wr     = w_access && s_apb_pwrite;
    assign w_rd     = w_access && !s_apb_pwrite;

    // Protection and byte strobes have no meaning for these registers.
    assign w_unused_apb = ^{s_apb_pprot, s_apb_pstrb, s_apb_pwdata};

    // Address decode. REG_NONE covers unaligned, unmapped and LOAD slots
    // beyond the implemented channels; those produce pslverr.
    always_comb begin
        w_addr     = int'(s_apb_paddr);
        w_sel      = REG_NONE;
        w_load_idx = 0;
        if (s_apb_paddr[1:0] == 2'b00) begin
            if (w_addr == C_OFF_CTRL) begin
                w_sel = REG_CTRL;
            end else if (w_addr == C_OFF_STATUS) begin
                w_sel = REG_STATUS;
            end else if (w_addr == C_OFF_DONE) begin
                w_sel = REG_DONE;
            end else if (w_addr == C_OFF_IRQ_EN) begin
                w_sel = REG_IRQ_EN;
            end else if (w_addr >= C_OFF_LOAD_BASE &&
                         w_addr <  C_OFF_LOAD_BASE + 4 * G_NUM_CH) begin
                w_sel      = REG_LOAD;
                w_load_idx = (w_addr - C_OFF_LOAD_BASE) >> 2;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < G_NUM_CH; gi++) begin : g_ch
            assign w_start[gi]   = w_wr && (w_sel == REG_CTRL) && s_apb_pwdata[gi];
            assign w_abort[gi]   = w_wr && (w_sel == REG_CTRL) &&
                                   s_apb_pwdata[C_CTRL_ABORT_BASE + gi];
            assign w_load_we[gi] = w_wr && (w_sel == REG_LOAD) && (w_load_idx == gi);

            apb_poll_timer_ch #(
                .G_CNT_WIDTH (G_CNT_WIDTH)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .i_start      (w_start[gi]),
                .i_abort      (w_abort[gi]),
                .i_load       (r_load[gi]),
                .o_busy       (busy[gi]),
                .o_done_pulse (w_done_pulse[gi])
            );
        end
    endgenerate

    assign w_done_w1c = (w_wr && (w_sel == REG_DONE)) ? s_apb_pwdata[G_NUM_CH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done   <= '0;
            r_irq_en <= '0;
            for (int i = 0; i < G_NUM_CH; i++) begin
                r_load[i] <= G_CNT_WIDTH'(C_LOAD_RST_VAL);
            end
        end else begin
            // Hardware set wins over a simultaneous write-1-to-clear.
            r_done <= (r_done & ~w_done_w1c) | w_done_pulse;
            if (w_wr && (w_sel == REG_IRQ_EN)) begin
                r_irq_en <= s_apb_pwdata[G_NUM_CH-1:0];
            end
            for (int i = 0; i < G_NUM_CH; i++) begin
                if (w_load_we[i]) begin
                    r_load[i] <= s_apb_pwdata[G_CNT_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_STATUS: w_rdata = G_REGWIDTH'(busy);
            REG_DONE:   w_rdata = G_REGWIDTH'(r_done);
            REG_IRQ_EN: w_rdata = G_REGWIDTH'(r_irq_en);
            REG_LOAD: begin
                for (int i = 0; i < G_NUM_CH; i++) begin
                    if (w_load_idx == i) begin
                        w_rdata = G_REGWIDTH'(r_load[i]);
                    end
                end
            end
            default:    w_rdata = '0;
        endcase
    end

    // Reset masks the combinational outputs so nothing leaks before the
    // registers have actually been cleared.
    assign s_apb_pready  = 1'b1;
    assign s_apb_prdata  = (w_rd && !rst) ? w_rdata : '0;
    assign s_apb_pslverr = w_access && !rst && (w_sel == REG_NONE);
    assign irq           = !rst && (|(r_done & r_irq_en));

endmodule

// File: tb/tb_apb_poll_timer.sv
module tb_apb_poll_timer;
    localparam int N  = 4;
    localparam int CW = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [2:0]    pprot;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic          pready;
    logic [31:0]   prdata;
    logic          pslverr;
    logic [N-1:0]  busy;
    logic          irq;

    apb_poll_timer #(
        .G_REGWIDTH(32), .G_ADDR_WIDTH(AW), .G_NUM_CH(N), .G_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
        .s_apb_pprot(pprot), .s_apb_paddr(paddr), .s_apb_pwdata(pwdata),
        .s_apb_pstrb(pstrb), .s_apb_pready(pready), .s_apb_prdata(prdata),
        .s_apb_pslverr(pslverr), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel tracks how many more cycles it stays busy.
    int           m_left [N];
    int           m_load [N];
    logic [N-1:0] m_done;
    logic [N-1:0] m_irq_en;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    function automatic bit m_err(input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        if (ai % 4 != 0) return 1'b1;
        if (ai <= 'h0C) return 1'b0;
        if (ai >= 'h10 && ai < 'h10 + 4 * N) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] m_busy();
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = (m_left[i] > 0);
        return b;
    endfunction

    function automatic logic m_irq();
        return |(m_done & m_irq_en);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        if (m_err(a)) return 32'h0;
        case (ai)
            'h00:    return 32'h0;
            'h04:    return 32'(m_busy());
            'h08:    return 32'(m_done);
            'h0C:    return 32'(m_irq_en);
            default: return 32'(m_load[(ai - 'h10) / 4]);
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [N-1:0] st, ab, w1c, hw_set;
        int ai;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_left[i] = 0;
                m_load[i] = 15;
            end
            m_done   = '0;
            m_irq_en = '0;
            return;
        end
        st = '0; ab = '0; w1c = '0; hw_set = '0;
        ai = int'(paddr);
        if (psel && penable && pwrite && !m_err(paddr)) begin
            if (ai == 'h00) begin
                st = pwdata[N-1:0];
                ab = pwdata[16 +: N];
            end else if (ai == 'h08) begin
                w1c = pwdata[N-1:0];
            end else if (ai == 'h0C) begin
                m_irq_en = pwdata[N-1:0];
            end else if (ai >= 'h10) begin
                m_load[(ai - 'h10) / 4] = int'(pwdata[CW-1:0]);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (st[i]) begin
                m_left[i] = m_load[i] + 1;
            end else if (ab[i]) begin
                m_left[i] = 0;
            end else if (m_left[i] > 0) begin
                m_left[i]--;
                if (m_left[i] == 0) hw_set[i] = 1'b1;
            end
        end
        m_done = (m_done & ~w1c) | hw_set;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(m_busy()));
        chk("irq", 32'(irq), 32'(m_irq()));
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        pstrb = 4'($urandom); pprot = 3'($urandom);
        #1;
        chk("setup_slverr", 32'(pslverr), 32'h0);
        step();
        penable = 1'b1;
        #1;
        chk($sformatf("wr%02h_slverr", a), 32'(pslverr), 32'(m_err(a)));
        chk("wr_prdata", prdata, 32'h0);
        chk("pready", 32'(pready), 32'h1);
        step();
        $display("WR addr=0x%02h data=0x%08h slverr=%0d", a, d, m_err(a));
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] rd);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        pstrb = 4'($urandom); pprot = 3'($urandom);
        #1;
        chk("setup_prdata", prdata, 32'h0);
        step();
        penable = 1'b1;
        #1;
        rd = prdata;
        chk($sformatf("rd%02h_data", a), prdata, m_rdata(a));
        chk($sformatf("rd%02h_slverr", a), 32'(pslverr), 32'(m_err(a)));
        step();
        $display("RD addr=0x%02h data=0x%08h slverr=%0d", a, rd, m_err(a));
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int c;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < N; i++) apb_read(AW'('h10 + 4 * i), rd);
        apb_read('h08, rd);
        apb_read('h0C, rd);

        // Single channel, default-style LOAD of 15, with interrupt.
        apb_write('h10, 15);
        apb_write('h0C, 1);
        apb_write('h00, 1);
        c = 0;
        while (busy[0] && c < 40) begin c++; step(); end
        chk("ch0_busy_len", c, 16);
        apb_read('h08, rd);
        chk("ch0_done", rd, 32'h1);
        chk("ch0_irq", 32'(irq), 32'h1);
        apb_write('h08, 1);
        chk("ch0_irq_clr", 32'(irq), 32'h0);

        // LOAD of zero: one busy cycle.
        apb_write('h18, 0);
        apb_write('h00, 4);
        c = 0;
        while (busy[2] && c < 40) begin c++; step(); end
        chk("ch2_busy_len", c, 1);
        apb_read('h08, rd);
        chk("ch2_done", rd, 32'h4);

        // Restart mid-count.
        apb_write('h08, 'hF);
        apb_write('h14, 10);
        apb_write('h00, 2);
        repeat (3) step();
        apb_write('h00, 2);
        apb_read('h08, rd);
        chk("ch1_no_early_done", rd, 32'h0);
        c = 0;
        while (busy[1] && c < 40) begin c++; step(); end
        chk("ch1_restart_len", 5 + 2 + c, 16);
        apb_read('h08, rd);
        chk("ch1_done", rd, 32'h2);

        // Abort, then start and abort together.
        apb_write('h00, 8);
        step();
        apb_write('h00, 'h80000);
        chk("ch3_abort_busy", 32'(busy[3]), 32'h0);
        apb_read('h08, rd);
        chk("ch3_abort_done", 32'(rd[3]), 32'h0);
        apb_write('h00, 'h80008);
        chk("ch3_start_wins", 32'(busy[3]), 32'h1);
        repeat (20) step();

        // Hardware DONE set coinciding with its W1C.
        apb_write('h08, 'hF);
        apb_write('h10, 3);
        apb_write('h00, 1);
        repeat (2) step();
        apb_write('h08, 1);
        apb_read('h08, rd);
        chk("set_beats_w1c", 32'(rd[0]), 32'h1);

        // Error accesses.
        apb_read('h02, rd);
        apb_read(AW'('h10 + 4 * N), rd);
        apb_write('h02, 32'hFFFF_FFFF);
        apb_write(AW'('h10 + 4 * N), 32'hFFFF_FFFF);
        apb_write('h7C, 32'hFFFF_FFFF);
        chk("err_busy", 32'(busy), 32'h0);
        for (int a = 0; a < 'h20; a += 4) apb_read(AW'(a), rd);

        // Reset in the middle of a count on all channels.
        apb_write('h18, 0);
        apb_write('h0C, 'hF);
        apb_write('h00, 4);
        step(); step();
        apb_write('h18, 20);
        apb_write('h00, 'hF);
        chk("pre_rst_busy", 32'(busy), 32'hF);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 'h08;
        #1;
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_pready", 32'(pready), 32'h1);
        paddr = 'h02;
        #1;
        chk("rst_slverr", 32'(pslverr), 32'h0);
        step();
        psel = 1'b0; penable = 1'b0; rst = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'h0);
        apb_read('h08, rd);
        chk("post_rst_done", rd, 32'h0);
        apb_read('h10, rd);
        chk("post_rst_load0", rd, 32'd15);

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            int kind;
            logic [31:0] d;
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: begin
                    d = 32'($urandom_range(0, 15)) | (32'($urandom_range(0, 15)) << 16);
                    if ($urandom_range(0, 3) == 0) d = d | ($urandom & 32'hFFF0_FFF0);
                    apb_write('h00, d);
                end
                3: begin
                    d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
                    apb_write(AW'('h10 + 4 * $urandom_range(0, N - 1)), d);
                end
                4: apb_write('h08, $urandom);
                5: apb_write('h0C, $urandom);
                6: apb_read(AW'(4 * $urandom_range(0, 3 + N)), rd);
                7: apb_read(AW'($urandom), rd);
                8: apb_write(AW'($urandom), $urandom);
                default: repeat ($urandom_range(1, 4)) step();
            endcase
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_poll_timer.md
APB_POLL_TIMER -- requirements
Module: apb_poll_timer

Interface
REQ-001 SHALL have parameter G_REGWIDTH, default 32: APB data width; legal value is 32 only.
REQ-002 SHALL have parameter G_ADDR_WIDTH, default 7: APB byte-address width.
REQ-003 SHALL have parameter G_NUM_CH, default 4: number of independent busy channels, 1..16.
REQ-004 SHALL have parameter G_CNT_WIDTH, default 8: per-channel countdown width, 1..32.
REQ-005 SHALL have ports clk (input, 1, the only clock) and rst (input, 1, synchronous active-high reset).
REQ-006 SHALL have APB slave inputs s_apb_psel, s_apb_penable and s_apb_pwrite (1 each), s_apb_pprot (3), s_apb_paddr (G_ADDR_WIDTH), s_apb_pwdata (G_REGWIDTH) and s_apb_pstrb (G_REGWIDTH/8).
REQ-007 SHALL have APB slave outputs s_apb_pready (1), s_apb_prdata (G_REGWIDTH) and s_apb_pslverr (1).
REQ-008 SHALL have output busy (G_NUM_CH): per-channel busy flags.
REQ-009 SHALL have output irq (1): level interrupt equal to OR of (DONE AND IRQ_EN).

Function
REQ-010 SHALL complete every APB transfer with zero wait states: s_apb_pready=1 constantly.
REQ-011 SHALL commit writes only in the access phase (psel and penable and pwrite) and SHALL ignore pprot and pstrb.
REQ-012 SHALL drive prdata combinationally during the access phase of a read and SHALL drive 0 at all other times.
REQ-013 SHALL use this register map (byte offsets):
- 0x00 CTRL, write-only, reads 0: bit[ch]=1 starts ch; bit[16+ch]=1 aborts ch.
- 0x04 STATUS, read-only: busy vector.
- 0x08 DONE, read / write-1-to-clear.
- 0x0C IRQ_EN, read/write, reset 0.
- 0x10+4*ch LOAD[ch], read/write, G_CNT_WIDTH bits zero-extended, reset 15.
REQ-014 SHALL assert pslverr for one access-phase cycle on any address that is unmapped, not word-aligned, or a LOAD index >= G_NUM_CH; the write SHALL be dropped and prdata SHALL be 0.
REQ-015 SHALL, on start of ch: in the next cycle, busy[ch]=1 and cnt[ch]=LOAD[ch].
REQ-016 SHALL, while busy[ch]=1 and cnt[ch]!=0, decrement cnt[ch] by 1 per cycle.
REQ-017 SHALL, while busy[ch]=1 and cnt[ch]==0, clear busy[ch] and set DONE[ch] in the next cycle.
- busy is therefore high for exactly LOAD+1 cycles (LOAD=0 gives 1 cycle).
REQ-018 SHALL restart a channel that is already busy by reloading cnt from LOAD, with no DONE set.
- This includes a restart on its terminal (cnt==0) cycle.
REQ-019 SHALL, on abort, clear busy[ch] and cnt[ch] in the next cycle without setting DONE; abort of an idle channel has no effect.
REQ-020 SHALL let start win when start and abort of the same channel are written together.
REQ-021 SHALL let set win when a DONE hardware set coincides with a W1C of the same bit.
REQ-022 SHALL not affect a running countdown when LOAD is written; the new value applies from the next start.
REQ-023 SHALL keep all channels fully independent; one CTRL write may start or abort any subset.
REQ-024 SHALL compute irq combinationally from the DONE and IRQ_EN registers.

Reset
REQ-025 SHALL, with rst high at a clk edge, set busy=0, cnt=0, DONE=0, IRQ_EN=0 and LOAD[*]=15.
REQ-026 SHALL, during reset, force irq=0, prdata=0 and pslverr=0 while pready stays 1.
REQ-027 SHALL abandon a countdown in progress on reset without setting DONE.

Structure
REQ-028 SHALL place register offsets, the CTRL abort bit base (16), the LOAD reset value (15) and G_NUM_CH limits in package apb_poll_timer_pkg.
REQ-029 SHALL implement one channel (start/abort/load in; busy/done_pulse out; counter and busy flag) as sub-module apb_poll_timer_ch, instantiated G_NUM_CH times.
REQ-030 SHALL keep the APB decode, DONE, IRQ_EN and LOAD registers in the top level.

Verification
REQ-031 SHALL cover single channel: LOAD[0]=15, write CTRL=0x1 -> busy[0] high 16 cycles, then DONE=0x1; with IRQ_EN=0x1, irq=1 until DONE written 0x1.
REQ-032 SHALL cover LOAD[2]=0 then start -> busy[2] high exactly 1 cycle and DONE[2] set.
REQ-033 SHALL cover restart: start ch1 with LOAD=10, restart at cycle 5 -> busy high 5+11 cycles and a single DONE set.
REQ-034 SHALL cover abort: start ch3, write CTRL=0x80000 at cycle 3 -> busy[3] low next cycle, DONE[3]=0; CTRL=0x80008 -> ch3 starts.
REQ-035 SHALL cover errors: read 0x02 and read 0x10+4*G_NUM_CH -> pslverr=1 and prdata=0; a write to either -> no register change.
REQ-036 SHALL cover reset mid-count: assert rst with busy=0xF -> busy=0, DONE=0, LOAD=15 and irq=0 after the edge.
